i2c_master_controller: RTL
==========================

I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 SHALL have parameter: CLK_DIV, 4, clk cycles per quarter SCL period (SCL period = 4*CLK_DIV clk cycles), legal range 1..255.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: enable  input  1  transaction request, sampled only while ready=1.
REQ-005 SHALL have port: addr  input  7  target address, captured on acceptance.
REQ-006 SHALL have port: rw  input  1  0=write one byte, 1=read one byte, captured on acceptance.
REQ-007 SHALL have port: wdata  input  8  write byte, captured on acceptance.
REQ-008 SHALL have port: rdata  output  8  last byte read.
REQ-009 SHALL have port: ready  output  1  1 when in IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at transaction end.
REQ-011 SHALL have port: ack_error  output  1  set when last transaction got a NACK.
REQ-012 SHALL have port: sda  inout  1  open-drain, driven 0 or released (z), never driven 1.
REQ-013 SHALL have port: scl  inout  1  open-drain, driven 0 or released (z), never driven 1.

Function
REQ-014 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, STOP.
REQ-015 SHALL split every bit slot into four quarters of CLK_DIV cycles: q0/q1 SCL low (SDA changes at q0 start), q2/q3 SCL released; SDA sampled at q3 start.
REQ-016 IDLE: both lines released, ready=1; enable=1 captures addr/rw/wdata, clears ack_error, enters START next cycle.
REQ-017 START: SDA pulled low while SCL high for 2 quarters, then SCL low for 2 quarters; then ADDR.
REQ-018 ADDR: shifts {addr,rw} MSB first, 8 bit slots; then ADDR_ACK.
REQ-019 ADDR_ACK: releases SDA for one slot; sampled 0 -> WRITE_DATA (rw=0) or READ_DATA (rw=1); sampled 1 -> ack_error=1, STOP.
REQ-020 WRITE_DATA: shifts wdata MSB first, 8 slots; WRITE_ACK samples as in ADDR_ACK; NACK sets ack_error; both outcomes -> STOP.
REQ-021 READ_DATA: SDA released, 8 slots sampled MSB first into shift register; rdata updated once after 8th bit; READ_ACK drives NACK (SDA released) for one slot -> STOP.
REQ-022 STOP: SDA low with SCL low (q0-q1), SCL released (q2), SDA released (q3); then IDLE with done=1 for exactly that cycle.
REQ-023 Latency enable-to-done: 80*CLK_DIV+1 cycles on full transaction; 44*CLK_DIV+1 on address NACK.
REQ-024 enable while ready=0 SHALL be ignored; captured inputs SHALL not change mid-transaction.
REQ-025 rdata and ack_error SHALL hold until next accepted transaction (rdata also survives write transactions).

Reset
REQ-026 rst_n=0 SHALL force, at next clk edge: state IDLE, sda/scl released, rdata=0, ready=1, done=0, ack_error=0, counters 0.
REQ-027 Reset mid-transaction SHALL abandon the transfer without generating STOP and without a done pulse.

Configuration
REQ-028 Macro I2C_MASTER_CLK_STRETCH_EN defined: quarter counter SHALL hold in q2 until scl input reads 1 (slave clock stretching honored; latency extends accordingly).
REQ-029 Macro undefined: scl input SHALL be ignored; timing purely counter-driven.

Verification (CLK_DIV=4, pull-ups on sda/scl, responder at address 0x2A returning 0xCC on reads)
REQ-030 Write: addr=0x2A, rw=0, wdata=0xA5 -> SDA bytes 0x54, 0xA5, two ACKs, ack_error=0, done 321 cycles after enable.
REQ-031 Read: addr=0x2A, rw=1 -> address byte 0x55, rdata=0xCC, master NACK in 9th slot, STOP, ack_error=0.
REQ-032 Wrong address: addr=0x15 -> SDA high in ACK slot, ack_error=1, STOP, done 177 cycles after enable, no data byte.
REQ-033 Reset mid-transfer: rst_n=0 during bit 3 of the address byte -> next cycle sda/scl released, ready=1, no done; new transaction then completes normally.
REQ-034 Busy guard: enable=1 with addr=0x15 while busy -> ignored, current transaction unaffected, single done pulse.
REQ-035 With I2C_MASTER_CLK_STRETCH_EN: responder holds SCL low 20 cycles after data bit 0 -> SCL high phase delayed 20 cycles, byte still correct, done delayed by 20 cycles.

Source files
------------

// File: rtl/i2c_master_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : i2c_master_controller                                        |
// | Desc     : Single-byte I2C master. Each transaction is START, address   |
// |            byte, ACK slot, then one write or read byte with its ACK     |
// |            slot, then STOP. SDA/SCL are open-drain (0 or released).     |
// |            Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock       |
// |            stretching during the SCL-high quarter.                      |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module i2c_master_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       done,
  output logic       ack_error,
  inout  wire        sda,
  inout  wire        scl
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    ADDR       = 4'd2,
    ADDR_ACK   = 4'd3,
    WRITE_DATA = 4'd4,
    WRITE_ACK  = 4'd5,
    READ_DATA  = 4'd6,
    READ_ACK   = 4'd7,
    STOP       = 4'd8
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_div;
  logic [1:0] r_quarter;
  logic [2:0] r_bit;
  logic [7:0] r_addr_byte;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_ack_sample;
  logic       r_ack_error;
  logic       r_done;

  logic       w_hold;
  logic       w_qtick;
  logic       w_slot_end;
  logic       w_sample;
  logic       w_bit_state;
  logic       w_last_bit;
  logic       w_scl_low;
  logic       w_sda_low;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // Freeze the quarter timer while a slave holds SCL low during the high phase.
  // START is excluded because the master itself pulls SCL low there.
  assign w_hold = (r_state != IDLE) && (r_state != START) &&
                  (r_quarter == 2'd2) && !scl;
`else
  // Timing is purely counter-driven; the SCL line is not consulted.
  logic w_unused_scl;
  assign w_unused_scl = scl;
  assign w_hold       = 1'b0;
`endif

  assign w_qtick     = (r_state != IDLE) && (r_div == c_div_last) && !w_hold;
  assign w_slot_end  = w_qtick && (r_quarter == 2'd3);
  assign w_sample    = w_qtick && (r_quarter == 2'd2);
  assign w_bit_state = (r_state == ADDR) || (r_state == WRITE_DATA) || (r_state == READ_DATA);
  assign w_last_bit  = (r_bit == 3'd7);

  // Open-drain pads: only ever pull low or release.
  assign sda       = w_sda_low ? 1'b0 : 1'bz;
  assign scl       = w_scl_low ? 1'b0 : 1'bz;
  assign ready     = (r_state == IDLE);
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign ack_error = r_ack_error;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Clock divider, quarter and bit counters; idle keeps them at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == IDLE)) begin
      r_div     <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
    end else if (!w_hold) begin
      if (r_div == c_div_last) begin
        r_div     <= '0;
        r_quarter <= r_quarter + 2'd1;
        if ((r_quarter == 2'd3) && w_bit_state) r_bit <= r_bit + 3'd1;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  // Request capture, SDA sampling, result registers and the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_byte  <= '0;
      r_wdata      <= '0;
      r_shift      <= '0;
      r_rdata      <= '0;
      r_ack_sample <= 1'b0;
      r_ack_error  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_slot_end;
      if ((r_state == IDLE) && enable) begin
        r_addr_byte <= {addr, rw};
        r_wdata     <= wdata;
        r_ack_error <= 1'b0;
      end
      if (w_sample && (r_state == READ_DATA)) r_shift      <= {r_shift[6:0], sda};
      else if (w_sample)                      r_ack_sample <= sda;
      if (w_slot_end) begin
        if (((r_state == ADDR_ACK) || (r_state == WRITE_ACK)) && r_ack_sample)
          r_ack_error <= 1'b1;
        if ((r_state == READ_DATA) && w_last_bit)
          r_rdata <= r_shift;
      end
    end
  end

  // Next-state sequencing and per-quarter line drive.
  always_comb begin
    w_next_state = r_state;
    w_scl_low    = 1'b0;
    w_sda_low    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_next_state = START;
      end
      START: begin
        w_sda_low = 1'b1;
        w_scl_low = r_quarter[1];
        if (w_slot_end) w_next_state = ADDR;
      end
      ADDR: begin
        w_scl_low = ~r_quarter[1];
        w_sda_low = ~r_addr_byte[~r_bit];
        if (w_slot_end && w_last_bit) w_next_state = ADDR_ACK;
      end
      ADDR_ACK: begin
        w_scl_low = ~r_quarter[1];
        if (w_slot_end) begin
          if (r_ack_sample)        w_next_state = STOP;
          else if (r_addr_byte[0]) w_next_state = READ_DATA;
          else                     w_next_state = WRITE_DATA;
        end
      end
      WRITE_DATA: begin
        w_scl_low = ~r_quarter[1];
        w_sda_low = ~r_wdata[~r_bit];
        if (w_slot_end && w_last_bit) w_next_state = WRITE_ACK;
      end
      WRITE_ACK: begin
        w_scl_low = ~r_quarter[1];
        if (w_slot_end) w_next_state = STOP;
      end
      READ_DATA: begin
        w_scl_low = ~r_quarter[1];
        if (w_slot_end && w_last_bit) w_next_state = READ_ACK;
      end
      READ_ACK: begin
        // Master NACK: SDA stays released for the whole slot.
        w_scl_low = ~r_quarter[1];
        if (w_slot_end) w_next_state = STOP;
      end
      STOP: begin
        w_scl_low = ~r_quarter[1];
        w_sda_low = (r_quarter != 2'd3);
        if (w_slot_end) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire
